// File: rtl/lmc_out_display.sv
// lmc_out_display
// Watches the CPU's 11-bit signed output register, converts each new value
// to sign + 3-digit BCD with a serial double-dabble engine (one step per
// clock), and drives a 4-digit multiplexed seven-segment display.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset
//   value_in  [10:0] signed value from the CPU output register
//   busy      conversion in progress
//   done      one-cycle pulse when bcd/neg/ovf update
//   bcd       [11:0] {hundreds, tens, units}
//   neg       latched value is negative
//   ovf       latched magnitude exceeds 999
//   seg       [6:0] segments {g,f,e,d,c,b,a}, active-high
//   an        [3:0] one-hot digit enable; an[0] units, an[3] sign
//
// state   | meaning
// IDLE    | compare value_in against the last captured value
// CONVERT | one double-dabble step per clock, 10 steps total
module lmc_out_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] value_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic        neg,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state, state_nxt;
  logic [10:0] shadow, shadow_nxt;
  logic [9:0]  sr, sr_nxt;
  logic [11:0] acc, acc_nxt;
  logic [3:0]  step, step_nxt;
  logic        sign_r, sign_nxt;
  logic        busy_nxt, done_nxt, neg_nxt, ovf_nxt;
  logic [11:0] bcd_nxt;

  logic [11:0] ext_in, mag_in;
  logic [11:0] acc_adj, acc_step;
  logic [9:0]  sr_step;

  // Sign-extend to 12 bits so that -1024 has a representable magnitude.
  assign ext_in = {value_in[10], value_in};
  assign mag_in = value_in[10] ? (~ext_in + 12'd1) : ext_in;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  assign acc_adj  = {dabble(acc[11:8]), dabble(acc[7:4]), dabble(acc[3:0])};
  assign acc_step = {acc_adj[10:0], sr[9]};
  assign sr_step  = {sr[8:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      shadow <= '0;
      sr     <= '0;
      acc    <= '0;
      step   <= '0;
      sign_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      bcd    <= '0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      sr     <= sr_nxt;
      acc    <= acc_nxt;
      step   <= step_nxt;
      sign_r <= sign_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      bcd    <= bcd_nxt;
      neg    <= neg_nxt;
      ovf    <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    sr_nxt     = sr;
    acc_nxt    = acc;
    step_nxt   = step;
    sign_nxt   = sign_r;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    bcd_nxt    = bcd;
    neg_nxt    = neg;
    ovf_nxt    = ovf;
    case (state)
      IDLE: begin
        if (value_in != shadow) begin
          shadow_nxt = value_in;
          if (mag_in > 12'd999) begin
            // Overflow needs no conversion; publish immediately.
            bcd_nxt  = '0;
            neg_nxt  = value_in[10];
            ovf_nxt  = 1'b1;
            done_nxt = 1'b1;
          end else begin
            sr_nxt    = mag_in[9:0];
            acc_nxt   = '0;
            step_nxt  = '0;
            sign_nxt  = value_in[10];
            busy_nxt  = 1'b1;
            state_nxt = CONVERT;
          end
        end
      end
      CONVERT: begin
        sr_nxt   = sr_step;
        acc_nxt  = acc_step;
        step_nxt = step + 4'd1;
        if (step == 4'd9) begin
          bcd_nxt   = acc_step;
          neg_nxt   = sign_r;
          ovf_nxt   = 1'b0;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Display multiplexing
  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [6:0]    digit_seg;
  logic [3:0]    hund, tens, units;

  assign hund  = bcd[11:8];
  assign tens  = bcd[7:4];
  assign units = bcd[3:0];

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    digit_seg = 7'h00;
    case (digit_idx)
      2'd0: digit_seg = seg_code(units);
      2'd1: if (!(hund == 4'd0 && tens == 4'd0)) digit_seg = seg_code(tens);
      2'd2: if (hund != 4'd0) digit_seg = seg_code(hund);
      2'd3: if (neg) digit_seg = 7'h40;
      default: digit_seg = 7'h00;
    endcase
    if (ovf) digit_seg = 7'h40;
  end

  // an/seg are registered from the current index so both move together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      an        <= '0;
      seg       <= '0;
    end else begin
      if (scan_cnt == CNT_MAX) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= 4'b0001 << digit_idx;
      seg <= digit_seg;
    end
  end

endmodule

// File: tb/tb_lmc_out_display.sv
module tb_lmc_out_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] value_in;
  logic        busy, done, neg, ovf;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [11:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  lmc_out_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value_in (value_in),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .neg      (neg),
    .ovf      (ovf),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < max);
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // One full rotation at SCAN_DIV=4 is 16 cycles.
  task automatic check_scan(input logic [6:0] s_u, input logic [6:0] s_t,
                            input logic [6:0] s_h, input logic [6:0] s_s);
    for (int c = 0; c < 16; c++) begin
      tick();
      case (an)
        4'b0001: chk("seg_units",    {25'd0, seg}, {25'd0, s_u});
        4'b0010: chk("seg_tens",     {25'd0, seg}, {25'd0, s_t});
        4'b0100: chk("seg_hundreds", {25'd0, seg}, {25'd0, s_h});
        4'b1000: chk("seg_sign",     {25'd0, seg}, {25'd0, s_s});
        default: chk("an_onehot",    {28'd0, an},  32'd1);
      endcase
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("sb_expected_done", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_bcd", {20'd0, bcd}, {20'd0, e.bcd});
        chk("sb_neg", {31'd0, neg}, {31'd0, e.neg});
        chk("sb_ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
  end

  initial begin
    int n;
    reset_n  = 1'b0;
    value_in = 11'd0;
    tick();
    tick();
    chk("rst_bcd",  {20'd0, bcd},  32'd0);
    chk("rst_neg",  {31'd0, neg},  32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_an",   {28'd0, an},   32'd0);
    chk("rst_seg",  {25'd0, seg},  32'd0);

    // Scan sequence after release: 4 cycles per digit.
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("scan0_an",  {28'd0, an},  32'h1);
      chk("scan0_seg", {25'd0, seg}, 32'h3F);
    end
    for (int d = 1; d < 4; d++) begin
      for (int i = 0; i < 4; i++) begin
        logic [3:0] exp_an;
        exp_an = 4'b0001 << d;
        tick();
        chk("scan_an",  {28'd0, an},  {28'd0, exp_an});
        chk("scan_seg", {25'd0, seg}, 32'h00);
        chk("scan_busy", {31'd0, busy}, 32'd0);
      end
    end

    // 123: busy E0..E9, done only at E10.
    value_in = 11'd123;
    sb.push_back('{bcd: 12'h123, neg: 1'b0, ovf: 1'b0});
    tick();
    chk("c123_busy_e0", {31'd0, busy}, 32'd1);
    chk("c123_done_e0", {31'd0, done}, 32'd0);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk("c123_busy", {31'd0, busy}, 32'd1);
      chk("c123_done", {31'd0, done}, 32'd0);
    end
    tick();
    chk("c123_done_e10", {31'd0, done}, 32'd1);
    chk("c123_busy_e10", {31'd0, busy}, 32'd0);
    chk("c123_bcd",      {20'd0, bcd},  32'h123);
    check_scan(7'h4F, 7'h5B, 7'h06, 7'h00);

    // -7
    value_in = 11'h7F9;
    sb.push_back('{bcd: 12'h007, neg: 1'b1, ovf: 1'b0});
    wait_done(20, n);
    chk("m7_latency", n, 32'd11);
    chk("m7_bcd", {20'd0, bcd}, 32'h007);
    chk("m7_neg", {31'd0, neg}, 32'd1);
    check_scan(7'h07, 7'h00, 7'h00, 7'h40);

    // Overflow: 1000 then -1024, back-to-back done, busy never set.
    value_in = 11'd1000;
    sb.push_back('{bcd: 12'h000, neg: 1'b0, ovf: 1'b1});
    tick();
    chk("o1000_done", {31'd0, done}, 32'd1);
    chk("o1000_busy", {31'd0, busy}, 32'd0);
    chk("o1000_ovf",  {31'd0, ovf},  32'd1);
    chk("o1000_neg",  {31'd0, neg},  32'd0);
    value_in = 11'h400;
    sb.push_back('{bcd: 12'h000, neg: 1'b1, ovf: 1'b1});
    tick();
    chk("o1024_done", {31'd0, done}, 32'd1);
    chk("o1024_busy", {31'd0, busy}, 32'd0);
    chk("o1024_ovf",  {31'd0, ovf},  32'd1);
    chk("o1024_neg",  {31'd0, neg},  32'd1);
    tick();
    chk("o1024_done_end", {31'd0, done}, 32'd0);
    chk("o1024_busy_end", {31'd0, busy}, 32'd0);
    check_scan(7'h40, 7'h40, 7'h40, 7'h40);

    // 500, then 999 mid-conversion; latest value wins after completion.
    value_in = 11'd500;
    sb.push_back('{bcd: 12'h500, neg: 1'b0, ovf: 1'b0});
    tick();
    tick();
    tick();
    tick();
    value_in = 11'd999;
    sb.push_back('{bcd: 12'h999, neg: 1'b0, ovf: 1'b0});
    wait_done(20, n);
    chk("c500_bcd", {20'd0, bcd}, 32'h500);
    wait_done(20, n);
    chk("c999_latency", n, 32'd11);
    chk("c999_bcd", {20'd0, bcd}, 32'h999);
    chk("c999_ovf", {31'd0, ovf}, 32'd0);

    value_in = 11'h419;
    sb.push_back('{bcd: 12'h999, neg: 1'b1, ovf: 1'b0});
    wait_done(20, n);
    chk("m999_bcd", {20'd0, bcd}, 32'h999);
    chk("m999_neg", {31'd0, neg}, 32'd1);

    // Reset mid-conversion aborts without done; 42 is recaptured after.
    value_in = 11'd42;
    tick();
    tick();
    tick();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bcd",  {20'd0, bcd},  32'd0);
    chk("abort_neg",  {31'd0, neg},  32'd0);
    chk("abort_ovf",  {31'd0, ovf},  32'd0);
    chk("abort_an",   {28'd0, an},   32'd0);
    chk("abort_seg",  {25'd0, seg},  32'd0);
    reset_n = 1'b1;
    sb.push_back('{bcd: 12'h042, neg: 1'b0, ovf: 1'b0});
    wait_done(20, n);
    chk("c42_latency", n, 32'd11);
    chk("c42_bcd", {20'd0, bcd}, 32'h042);
    check_scan(7'h5B, 7'h66, 7'h00, 7'h00);

    tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
